// File: rtl/m92_bg_fetch.sv
// m92_bg_fetch: per-line M92 background tile fetcher; define BG_FLIP_EN to honour attribute flipx/flipy
module m92_bg_fetch #(
  parameter int TILES_PER_LINE = 41
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [8:0]  line_y,
  input  logic [9:0]  scroll_x,
  input  logic [9:0]  scroll_y,
  input  logic [1:0]  map_base,
  input  logic [24:0] gfx_base,
  output logic [14:0] vram_addr,
  input  logic [15:0] vram_q,
  output logic [24:0] sdr_addr,
  output logic        sdr_req,
  input  logic        sdr_rdy,
  input  logic [63:0] sdr_data,
  output logic [9:0]  line_wr_addr,
  output logic [11:0] line_wr_data,
  output logic        line_wr_en,
  output logic        busy,
  output logic        done
);
  localparam logic [2:0] IDLE = 3'd0, ATTR0 = 3'd1, ATTR1 = 3'd2, CAPT = 3'd3, REQ = 3'd4, EMIT = 3'd5, DONE = 3'd6;
  localparam logic [5:0] LAST = 6'(TILES_PER_LINE - 1);
  logic [2:0]  state, p, fy, fx, ry, n;
  logic [5:0]  i, row, col0, col;
  logic [15:0] code;
  logic [6:0]  pal;
  logic        prio, ry0, pend;
  logic [31:0] gfx;
  logic [8:0]  y;
  logic [9:0]  q;
  logic        unused_bits;
  assign unused_bits = ^{scroll_x[9], scroll_y[9]};
  assign y = line_y + scroll_y[8:0];
  assign col = col0 + i;
  assign q = {1'b0, i, p};
`ifdef BG_FLIP_EN
  logic flipx;
  // flipx is held through EMIT; flipy is only needed in CAPT, straight off vram_q
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) flipx <= 1'b0;
    else if (state == CAPT) flipx <= vram_q[9];
  assign ry = fy ^ {3{vram_q[10]}};
  assign n = p ^ {3{flipx}};
`else
  assign ry = fy;
  assign n = p;
`endif
  // Line/tile sequencer; a line_start in REQ is deferred until the SDRAM beat is drained
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      i <= '0;
      p <= '0;
      row <= '0;
      fy <= '0;
      col0 <= '0;
      fx <= '0;
      code <= '0;
      pal <= '0;
      prio <= 1'b0;
      ry0 <= 1'b0;
      pend <= 1'b0;
      gfx <= '0;
      sdr_addr <= '0;
    end else begin
      if (line_start) begin
        row <= y[8:3];
        fy <= y[2:0];
        col0 <= scroll_x[8:3];
        fx <= scroll_x[2:0];
        i <= '0;
      end
      if (state == REQ) begin
        if (sdr_rdy) begin
          state <= (line_start || pend) ? ATTR0 : EMIT;
          pend <= 1'b0;
          p <= '0;
          gfx <= ry0 ? sdr_data[63:32] : sdr_data[31:0];
        end else pend <= pend | line_start;
      end else if (line_start) state <= ATTR0;
      else case (state)
        ATTR0: state <= ATTR1;
        ATTR1: begin
          code <= vram_q;
          state <= CAPT;
        end
        CAPT: begin
          pal <= vram_q[6:0];
          prio <= vram_q[7];
          ry0 <= ry[0];
          sdr_addr <= gfx_base + {4'd0, code, ry[2:1], 3'b000};
          state <= REQ;
        end
        EMIT: begin
          p <= p + 3'd1;
          if (p == 3'd7) begin
            state <= (i == LAST) ? DONE : ATTR0;
            if (i != LAST) i <= i + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  // Outputs decode from registered state so they all read 0 out of reset
  always_comb begin
    vram_addr = (state == ATTR0 || state == ATTR1) ? {map_base, row, col, state == ATTR1} : '0;
    sdr_req = state == REQ;
    busy = state != IDLE && state != DONE;
    done = state == DONE;
    line_wr_en = state == EMIT && q >= {7'd0, fx};
    line_wr_addr = line_wr_en ? q - {7'd0, fx} : '0;
    line_wr_data = line_wr_en ? {prio, pal, gfx[{n, 2'b00} +: 4]} : '0;
  end
endmodule

// File: tb/tb_m92_bg_fetch.sv
// tb_m92_bg_fetch: directed tests of m92_bg_fetch against VRAM/SDRAM models
module tb_m92_bg_fetch;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic [8:0]  line_y = '0;
  logic [9:0]  scroll_x = '0;
  logic [9:0]  scroll_y = '0;
  logic [1:0]  map_base = '0;
  logic [24:0] gfx_base = '0;
  logic [14:0] vram_addr;
  logic [15:0] vram_q = '0;
  logic [24:0] sdr_addr;
  logic        sdr_req;
  logic        sdr_rdy;
  logic [63:0] sdr_data;
  logic [9:0]  line_wr_addr;
  logic [11:0] line_wr_data;
  logic        line_wr_en;
  logic        busy;
  logic        done;

  m92_bg_fetch dut (
    .clk(clk), .reset_n(reset_n), .line_start(line_start), .line_y(line_y),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .map_base(map_base), .gfx_base(gfx_base),
    .vram_addr(vram_addr), .vram_q(vram_q), .sdr_addr(sdr_addr), .sdr_req(sdr_req),
    .sdr_rdy(sdr_rdy), .sdr_data(sdr_data), .line_wr_addr(line_wr_addr),
    .line_wr_data(line_wr_data), .line_wr_en(line_wr_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [15:0] vram [0:32767];
  logic [11:0] wbuf [0:1023];
  logic [24:0] rdy_addr [0:63];
  logic [24:0] prev_addr = '0;
  logic        prev_req = 1'b0, prev_rdy = 1'b0;
  int cyc = 0, t0 = 0, rdy_delay = 0, wait_cnt = 0;
  int wr_cnt = 0, done_cnt = 0, done_cyc = 0, rdy_n = 0, addr_bad = 0, reassert = 0;
  int n_vec = 0, n_err = 0;

  always @(posedge clk) vram_q <= vram[vram_addr];
  assign sdr_data = 64'hFEDCBA98_76543210;
  assign sdr_rdy = sdr_req && wait_cnt >= rdy_delay;
  always @(posedge clk) wait_cnt <= (sdr_req && !sdr_rdy) ? wait_cnt + 1 : 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (line_wr_en) begin
      wr_cnt++;
      wbuf[line_wr_addr] = line_wr_data;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (sdr_req && sdr_rdy && rdy_n < 64) begin
      rdy_addr[rdy_n] = sdr_addr;
      rdy_n++;
    end
    if (sdr_req && prev_req && sdr_addr !== prev_addr) addr_bad++;
    if (sdr_req && prev_rdy) reassert++;
    prev_req = sdr_req;
    prev_rdy = sdr_rdy;
    prev_addr = sdr_addr;
  end

  task automatic start_line(input logic [8:0] ly, input logic [9:0] sx, input logic [9:0] sy);
    @(posedge clk);
    #1;
    wr_cnt = 0;
    done_cnt = 0;
    rdy_n = 0;
    for (int k = 0; k < 1024; k++) wbuf[k] = 12'hFFF;
    line_y = ly;
    scroll_x = sx;
    scroll_y = sy;
    line_start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    line_start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    while (done_cnt == 0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (done_cnt == 0) begin
      $display("FAIL done_timeout: no done within %0d cycles", lim);
      n_err++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    int k = 0;
    int w;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, sdr_req, line_wr_en, vram_addr, sdr_addr, line_wr_addr, line_wr_data} !== '0) begin
      $display("FAIL reset_outputs: got busy=%b req=%b en=%b va=%h sa=%h want all 0", busy, sdr_req, line_wr_en, vram_addr, sdr_addr);
      n_err++;
    end
    reset_n = 1'b1;
    vram[0] = 16'h0012;
    vram[1] = 16'h0005;
    start_line(9'd0, 10'd0, 10'd0);
    while (!line_wr_en && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, sdr_req, line_wr_en, vram_addr, sdr_addr, line_wr_addr, line_wr_data} !== '0) begin
      $display("FAIL reset_mid_emit: got busy=%b req=%b en=%b va=%h sa=%h wa=%h wd=%h want all 0", busy, sdr_req, line_wr_en, vram_addr, sdr_addr, line_wr_addr, line_wr_data);
      n_err++;
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    w = wr_cnt;
    repeat (20) @(negedge clk);
    n_vec++;
    if (sdr_req !== 1'b0 || busy !== 1'b0 || wr_cnt != w) begin
      $display("FAIL reset_idle: got req=%b busy=%b writes=%0d want req=0 busy=0 writes=%0d", sdr_req, busy, wr_cnt, w);
      n_err++;
    end
  endtask

  task automatic test_zero_scroll;
    vram[0] = 16'h0012;
    vram[1] = 16'h0005;
    start_line(9'd0, 10'd0, 10'd0);
    n_vec++;
    if (busy !== 1'b1) begin
      $display("FAIL zero_busy: got %b want 1", busy);
      n_err++;
    end
    wait_done(700);
    n_vec++;
    if (rdy_addr[0] !== 25'h240) begin
      $display("FAIL zero_sdr_addr: got %h want 000240", rdy_addr[0]);
      n_err++;
    end
    n_vec++;
    if (wbuf[0] !== 12'h050 || wbuf[7] !== 12'h057) begin
      $display("FAIL zero_tile0: got %h/%h want 050/057", wbuf[0], wbuf[7]);
      n_err++;
    end
    n_vec++;
    if (wbuf[8] !== 12'h000 || wbuf[15] !== 12'h007 || wbuf[327] !== 12'h007) begin
      $display("FAIL zero_tile1: got %h/%h/%h want 000/007/007", wbuf[8], wbuf[15], wbuf[327]);
      n_err++;
    end
    n_vec++;
    if (wr_cnt != 328 || done_cnt != 1) begin
      $display("FAIL zero_counts: got writes=%0d dones=%0d want 328/1", wr_cnt, done_cnt);
      n_err++;
    end
    n_vec++;
    if (done_cyc - t0 != 493) begin
      $display("FAIL zero_done_cycle: got %0d want 493", done_cyc - t0);
      n_err++;
    end
    n_vec++;
    if (busy !== 1'b0 || rdy_n != 41) begin
      $display("FAIL zero_end: got busy=%b reqs=%0d want 0/41", busy, rdy_n);
      n_err++;
    end
  endtask

  task automatic test_fine_scroll;
    start_line(9'd0, 10'd3, 10'd0);
    wait_done(700);
    n_vec++;
    if (wbuf[0] !== 12'h053 || wbuf[4] !== 12'h057 || wbuf[5] !== 12'h000) begin
      $display("FAIL fine_pixels: got %h/%h/%h want 053/057/000", wbuf[0], wbuf[4], wbuf[5]);
      n_err++;
    end
    n_vec++;
    if (wr_cnt != 325 || wbuf[324] !== 12'h007 || wbuf[325] !== 12'hFFF) begin
      $display("FAIL fine_count: got writes=%0d last=%h past=%h want 325/007/fff", wr_cnt, wbuf[324], wbuf[325]);
      n_err++;
    end
  endtask

  task automatic test_wrap;
    vram[126] = 16'h0012;
    vram[127] = 16'h0005;
    vram[0] = 16'h0034;
    vram[1] = 16'h0003;
    start_line(9'd1, 10'h1F8, 10'd511);
    wait_done(700);
    n_vec++;
    if (rdy_addr[0] !== 25'h240 || rdy_addr[1] !== 25'h680) begin
      $display("FAIL wrap_addr: got %h/%h want 000240/000680", rdy_addr[0], rdy_addr[1]);
      n_err++;
    end
    n_vec++;
    if (wbuf[0] !== 12'h050 || wbuf[8] !== 12'h030) begin
      $display("FAIL wrap_pixels: got %h/%h want 050/030", wbuf[0], wbuf[8]);
      n_err++;
    end
    vram[126] = 16'h0000;
    vram[127] = 16'h0000;
  endtask

  task automatic test_row_fy;
    map_base = 2'd2;
    vram[15'h4080] = 16'h0012;
    vram[15'h4081] = 16'h0005;
    start_line(9'd13, 10'd0, 10'd0);
    wait_done(700);
    n_vec++;
    if (rdy_addr[0] !== 25'h250) begin
      $display("FAIL rowfy_addr: got %h want 000250", rdy_addr[0]);
      n_err++;
    end
    n_vec++;
    if (wbuf[0] !== 12'h058 || wbuf[7] !== 12'h05F) begin
      $display("FAIL rowfy_pixels: got %h/%h want 058/05f", wbuf[0], wbuf[7]);
      n_err++;
    end
    map_base = 2'd0;
  endtask

  task automatic test_flip;
    logic [24:0] ea;
    logic [11:0] e0, e7;
`ifdef BG_FLIP_EN
    ea = 25'h258;
    e0 = 12'h85F;
    e7 = 12'h858;
`else
    ea = 25'h240;
    e0 = 12'h850;
    e7 = 12'h857;
`endif
    vram[0] = 16'h0012;
    vram[1] = 16'h0685;
    start_line(9'd0, 10'd0, 10'd0);
    wait_done(700);
    n_vec++;
    if (rdy_addr[0] !== ea) begin
      $display("FAIL flip_addr: got %h want %h", rdy_addr[0], ea);
      n_err++;
    end
    n_vec++;
    if (wbuf[0] !== e0 || wbuf[7] !== e7) begin
      $display("FAIL flip_pixels: got %h/%h want %h/%h", wbuf[0], wbuf[7], e0, e7);
      n_err++;
    end
  endtask

  task automatic test_abort;
    int k = 0;
    vram[0] = 16'h0012;
    vram[1] = 16'h0005;
    rdy_delay = 20;
    addr_bad = 0;
    reassert = 0;
    start_line(9'd0, 10'd0, 10'd0);
    while (!sdr_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    start_line(9'd5, 10'd0, 10'd0);
    n_vec++;
    if (sdr_req !== 1'b1) begin
      $display("FAIL abort_req_held: got %b want 1", sdr_req);
      n_err++;
    end
    wait_done(3000);
    repeat (20) @(negedge clk);
    n_vec++;
    if (done_cnt != 1 || wr_cnt != 328 || rdy_n != 42) begin
      $display("FAIL abort_counts: got dones=%0d writes=%0d beats=%0d want 1/328/42", done_cnt, wr_cnt, rdy_n);
      n_err++;
    end
    n_vec++;
    if (rdy_addr[0] !== 25'h240 || rdy_addr[1] !== 25'h250 || wbuf[0] !== 12'h058) begin
      $display("FAIL abort_restart: got %h/%h px=%h want 000240/000250 px=058", rdy_addr[0], rdy_addr[1], wbuf[0]);
      n_err++;
    end
    n_vec++;
    if (addr_bad != 0 || reassert != 0) begin
      $display("FAIL abort_handshake: got unstable=%0d reassert=%0d want 0/0", addr_bad, reassert);
      n_err++;
    end
    rdy_delay = 0;
  endtask

  task automatic test_back_to_back;
    int k = 0;
    start_line(9'd0, 10'd0, 10'd0);
    while (!done && k < 700) begin
      @(negedge clk);
      k++;
    end
    line_start = 1'b1;
    @(posedge clk);
    #1;
    line_start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || done_cnt != 1) begin
      $display("FAIL b2b_restart: got busy=%b dones=%0d want 1/1", busy, done_cnt);
      n_err++;
    end
    done_cnt = 0;
    wait_done(700);
    n_vec++;
    if (done_cnt != 1 || wr_cnt != 656) begin
      $display("FAIL b2b_second: got dones=%0d writes=%0d want 1/656", done_cnt, wr_cnt);
      n_err++;
    end
  endtask

  initial begin
    for (int k = 0; k < 32768; k++) vram[k] = 16'h0000;
    for (int k = 0; k < 64; k++) rdy_addr[k] = '0;
    test_reset;
    test_zero_scroll;
    test_fine_scroll;
    test_wrap;
    test_row_fy;
    test_flip;
    test_abort;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
